// File: rtl/context_manage_n_pkg.sv
// context_manage_n_pkg: shared constants for the speculative context manager.
// Provides the default context count and id width, the one-hot initial context
// mask, and a helper that packs the two allocated context ids (taken,
// fall-through) into the decode-to-exec info word.
package context_manage_n_pkg;
    localparam int CNTX_N = 8;
    localparam int CNTX_ID_W = $clog2(CNTX_N);
    localparam logic [CNTX_N-1:0] CONTEXT_INIT = CNTX_N'(1);

    function automatic logic [2*CNTX_ID_W-1:0] pack_dec_info(
        input logic [CNTX_ID_W-1:0] cid_t,
        input logic [CNTX_ID_W-1:0] cid_f
    );
        return {cid_t, cid_f};
    endfunction
endpackage

// File: rtl/context_manage_n_alloc2.sv
// context_manage_n_alloc2: picks the two lowest-index free contexts.
// Ports: free   - one bit per context, 1 = free
//        first  - one-hot lowest free context
//        second - one-hot second-lowest free context
//        ok     - both picks exist
module context_manage_n_alloc2
    import context_manage_n_pkg::*;
#(
    parameter int N = CNTX_N
) (
    input  logic [N-1:0] free,
    output logic [N-1:0] first,
    output logic [N-1:0] second,
    output logic         ok
);
    logic [N-1:0] rest;

    // x & -x isolates the lowest set bit
    always_comb begin
        first  = free & (~free + N'(1));
        rest   = free & ~first;
        second = rest & (~rest + N'(1));
        ok     = |second;
    end
endmodule

// File: rtl/context_manage_n.sv
// context_manage_n: speculative fetch context manager for the front end.
// Tracks N_CNTX contexts (valid, pending, next PC, kill mask of self plus
// speculative descendants), drives the fetch port for the hot context,
// allocates two contexts per decoded branch, kills subtrees on hazards and
// frees contexts on commit release.
// Ports: clk/rstn (async active-low), init (sync restart, top priority);
//        fetch_req/fetch_ack/fetch_pc/fetch_cid - fetch handshake;
//        iw_ready - instruction window has room;
//        dec_* - decode result, dec_cid_t/dec_cid_f - contexts allocated;
//        jmp_* - late next PC from exec; hz_* - mispredict kill;
//        rel_* - commit release; branch_hazard/kill_mask - registered kill
//        report; free_cnt - number of free contexts.
// Optional: define CTX_PERF_EN to add saturating perf_hazards,
//           perf_alloc_stalls and perf_fetches counters.
module context_manage_n
    import context_manage_n_pkg::*;
#(
    parameter int                N_CNTX   = CNTX_N,
    parameter int                CID_W    = $clog2(N_CNTX),
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              init,
    output logic              fetch_req,
    input  logic              fetch_ack,
    output logic [WORD_W-1:0] fetch_pc,
    output logic [CID_W-1:0]  fetch_cid,
    input  logic              iw_ready,
    input  logic              dec_valid,
    input  logic              dec_npc_ready,
    input  logic [WORD_W-1:0] dec_npc,
    input  logic              dec_branch,
    input  logic [WORD_W-1:0] dec_npc_f,
    output logic [CID_W-1:0]  dec_cid_t,
    output logic [CID_W-1:0]  dec_cid_f,
    input  logic              jmp_valid,
    input  logic [CID_W-1:0]  jmp_cid,
    input  logic [WORD_W-1:0] jmp_pc,
    input  logic              hz_valid,
    input  logic [CID_W-1:0]  hz_cid,
    input  logic [CID_W-1:0]  hz_safe_cid,
    input  logic              rel_valid,
    input  logic [CID_W-1:0]  rel_cid,
    output logic              branch_hazard,
    output logic [N_CNTX-1:0] kill_mask,
    output logic [CID_W:0]    free_cnt
`ifdef CTX_PERF_EN
    ,
    output logic [31:0]       perf_hazards,
    output logic [31:0]       perf_alloc_stalls,
    output logic [31:0]       perf_fetches
`endif
);
    logic [N_CNTX-1:0] valid, pending, n_valid, n_pending;
    logic [WORD_W-1:0] pc [N_CNTX];
    logic [WORD_W-1:0] n_pc [N_CNTX];
    logic [N_CNTX-1:0] mask [N_CNTX];
    logic [N_CNTX-1:0] n_mask [N_CNTX];
    logic [CID_W-1:0]  hot, n_hot, t_idx, f_idx;
    logic [N_CNTX-1:0] kill, t_oh, f_oh, n_km;
    logic              hot_killed, dec_ok, do_alloc, alloc_ok, n_bh;

    // allocation sees only contexts free at the start of the cycle, so a
    // context released or killed this cycle is not reused until the next one
    context_manage_n_alloc2 #(.N(N_CNTX)) u_alloc (
        .free   (~valid),
        .first  (t_oh),
        .second (f_oh),
        .ok     (alloc_ok)
    );

    always_comb begin
        free_cnt = '0;
        t_idx = '0;
        f_idx = '0;
        for (int i = 0; i < N_CNTX; i++) begin
            free_cnt = free_cnt + {{CID_W{1'b0}}, ~valid[i]};
            if (t_oh[i]) t_idx = CID_W'(i);
            if (f_oh[i]) f_idx = CID_W'(i);
        end
    end

    assign fetch_req  = valid[hot] & pending[hot] & iw_ready & (free_cnt >= (CID_W+1)'(2)) & ~init;
    assign fetch_pc   = pc[hot];
    assign fetch_cid  = hot;
    assign kill       = mask[hz_cid];
    assign hot_killed = hz_valid & kill[hot];
    // a decode belonging to a context killed this cycle is discarded
    assign dec_ok     = dec_valid & valid[hot] & ~hot_killed;
    assign do_alloc   = dec_ok & dec_branch & alloc_ok;
    assign dec_cid_t  = do_alloc ? t_idx : '0;
    assign dec_cid_f  = do_alloc ? f_idx : '0;

    // event order: hazard, release, jump, fetch/decode; init overrides all
    always_comb begin
        n_valid   = valid;
        n_pending = pending;
        n_pc      = pc;
        n_mask    = mask;
        n_hot     = hot;
        n_bh      = hot_killed;
        n_km      = hz_valid ? kill : '0;
        if (hz_valid) begin
            n_valid   &= ~kill;
            n_pending &= ~kill;
            for (int i = 0; i < N_CNTX; i++) n_mask[i] &= ~kill;
            if (hot_killed) n_hot = hz_safe_cid;
        end
        if (rel_valid) begin
            n_valid[rel_cid]   = 1'b0;
            n_pending[rel_cid] = 1'b0;
            n_mask[rel_cid]    = '0;
            for (int i = 0; i < N_CNTX; i++) n_mask[i][rel_cid] = 1'b0;
        end
        if (jmp_valid && n_valid[jmp_cid]) begin
            n_pc[jmp_cid]      = jmp_pc;
            n_pending[jmp_cid] = 1'b1;
        end
        if (fetch_req && fetch_ack) n_pending[hot] = 1'b0;
        if (dec_ok && !dec_branch && dec_npc_ready) begin
            n_pc[hot]      = dec_npc;
            n_pending[hot] = 1'b1;
        end
        if (do_alloc) begin
            // every ancestor of hot (and hot itself) now covers both children
            for (int i = 0; i < N_CNTX; i++)
                if (n_mask[i][hot]) n_mask[i] |= t_oh | f_oh;
            n_valid       |= t_oh | f_oh;
            n_pending     |= t_oh | f_oh;
            n_pc[t_idx]   = dec_npc;
            n_pc[f_idx]   = dec_npc_f;
            n_mask[t_idx] = t_oh;
            n_mask[f_idx] = f_oh;
            n_hot         = t_idx;
        end
        if (init) begin
            for (int i = 0; i < N_CNTX; i++) begin
                n_pc[i]   = '0;
                n_mask[i] = '0;
            end
            n_valid   = N_CNTX'(1);
            n_pending = N_CNTX'(1);
            n_pc[0]   = RESET_PC;
            n_mask[0] = N_CNTX'(1);
            n_hot     = '0;
            n_bh      = 1'b0;
            n_km      = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid         <= '0;
            pending       <= '0;
            hot           <= '0;
            branch_hazard <= 1'b0;
            kill_mask     <= '0;
            for (int i = 0; i < N_CNTX; i++) begin
                pc[i]   <= '0;
                mask[i] <= '0;
            end
        end else begin
            valid         <= n_valid;
            pending       <= n_pending;
            hot           <= n_hot;
            branch_hazard <= n_bh;
            kill_mask     <= n_km;
            pc            <= n_pc;
            mask          <= n_mask;
        end
    end

`ifdef CTX_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_hazards      <= '0;
            perf_alloc_stalls <= '0;
            perf_fetches      <= '0;
        end else if (init) begin
            perf_hazards      <= '0;
            perf_alloc_stalls <= '0;
            perf_fetches      <= '0;
        end else begin
            if (branch_hazard && !(&perf_hazards)) perf_hazards <= perf_hazards + 32'd1;
            if (valid[hot] && pending[hot] && free_cnt < (CID_W+1)'(2) && !(&perf_alloc_stalls))
                perf_alloc_stalls <= perf_alloc_stalls + 32'd1;
            if (fetch_req && fetch_ack && !(&perf_fetches)) perf_fetches <= perf_fetches + 32'd1;
        end
    end
`endif
endmodule
